// File: rtl/lamp_ramp_sequencer_pkg.sv
// Shared lighting definitions: lamp-count width, maximum lamp count, and ramp FSM states.
package lamp_ramp_sequencer_pkg;

  localparam int unsigned LAMP_CNT_W = 4;
  localparam int unsigned LAMP_MAX   = 15;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } lamp_state_e;

endpackage

// File: rtl/lamp_thermo_decode.sv
// Lamp count to thermometer enables: bit i is high iff i < count.
module lamp_thermo_decode
  import lamp_ramp_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LAMPS = LAMP_MAX
) (
  input  logic [LAMP_CNT_W-1:0] count,
  output logic [NUM_LAMPS-1:0]  therm
);

  always_comb begin
    therm = '0;
    for (int unsigned i = 0; i < NUM_LAMPS; i++) begin
      therm[i] = (i < 32'(count));
    end
  end

endmodule

// File: rtl/lamp_ramp_sequencer.sv
// Ramps the number of lit lamps one step per STEP_CYCLES toward the requested count,
// following target changes mid-ramp and pulsing done when a ramp lands on its target.
module lamp_ramp_sequencer
  import lamp_ramp_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LAMPS   = 15,
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LAMP_CNT_W-1:0] active_lights,
  output logic [NUM_LAMPS-1:0]  lamp_en,
  output logic [LAMP_CNT_W-1:0] on_count,
  output logic                  busy,
  output logic                  done
);

  localparam logic [LAMP_CNT_W-1:0] MAX_CNT   = LAMP_CNT_W'(NUM_LAMPS);
  localparam logic [3:0]            TIMER_END = 4'(STEP_CYCLES - 1);

  lamp_state_e           state_q, state_d;
  logic [LAMP_CNT_W-1:0] tgt_q, tgt_d;
  logic [LAMP_CNT_W-1:0] on_count_q, on_count_d;
  logic [3:0]            timer_q, timer_d;
  logic                  done_q, done_d;
  logic                  step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tgt_q      <= '0;
      on_count_q <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      on_count_q <= on_count_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
    end
  end

  assign step = (timer_q == TIMER_END);

  always_comb begin
    tgt_d      = (active_lights > MAX_CNT) ? MAX_CNT : active_lights;
    state_d    = state_q;
    on_count_d = on_count_q;
    timer_d    = timer_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (tgt_q > on_count_q)      state_d = RAMP_UP;
        else if (tgt_q < on_count_q) state_d = RAMP_DOWN;
      end

      // Target moving onto the current count ends the ramp silently; a target
      // behind the count reverses direction and restarts the step interval.
      RAMP_UP: begin
        if (tgt_q == on_count_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (tgt_q < on_count_q) begin
          state_d = RAMP_DOWN;
          timer_d = '0;
        end else if (step) begin
          timer_d    = '0;
          on_count_d = on_count_q + 1'b1;
          if (on_count_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      RAMP_DOWN: begin
        if (tgt_q == on_count_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (tgt_q > on_count_q) begin
          state_d = RAMP_UP;
          timer_d = '0;
        end else if (step) begin
          timer_d    = '0;
          on_count_d = on_count_q - 1'b1;
          if (on_count_d == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  lamp_thermo_decode #(.NUM_LAMPS(NUM_LAMPS)) u_decode (
    .count (on_count_q),
    .therm (lamp_en)
  );

  assign on_count = on_count_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_lamp_ramp_sequencer.sv
// Directed bench for lamp_ramp_sequencer: default, 12-lamp and single-cycle-step instances.
module tb_lamp_ramp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  al, al12, al1;
  logic [14:0] lamp_en;
  logic [11:0] lamp_en12;
  logic [14:0] lamp_en1;
  logic [3:0]  on_count, on_count12, on_count1;
  logic        busy, busy12, busy1;
  logic        done, done12, done1;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int done_cnt = 0;
  logic [3:0] prev_on;

  always #5 clk = ~clk;

  lamp_ramp_sequencer dut (
    .clk(clk), .rst_n(rst_n), .active_lights(al),
    .lamp_en(lamp_en), .on_count(on_count), .busy(busy), .done(done)
  );

  lamp_ramp_sequencer #(.NUM_LAMPS(12), .STEP_CYCLES(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .active_lights(al12),
    .lamp_en(lamp_en12), .on_count(on_count12), .busy(busy12), .done(done12)
  );

  lamp_ramp_sequencer #(.NUM_LAMPS(15), .STEP_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .active_lights(al1),
    .lamp_en(lamp_en1), .on_count(on_count1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the given edge of the current phase.
  task automatic to_edge(input int e);
    if (e > edge_n) begin
      repeat (e - edge_n) @(posedge clk);
      edge_n = e;
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n) begin
      assert (on_count <= 4'd15) else $error("on_count out of range");
      assert (on_count12 <= 4'd12) else $error("on_count12 out of range");
      assert ((on_count == prev_on) || (on_count == prev_on + 4'd1) || (on_count + 4'd1 == prev_on))
        else $error("on_count jumped by more than one");
    end
    prev_on = on_count;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; al = 4'd0; al12 = 4'd0; al1 = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("rst_lamp_en", 32'(lamp_en), 32'h0);
      check("rst_on_count", 32'(on_count), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
    end

    // Ramp 0 -> 3, plus 12-lamp clamp and single-cycle-step instances.
    rst_n = 1'b1; al = 4'd3; al12 = 4'd15; al1 = 4'd3; edge_n = 0; done_cnt = 0;
    to_edge(1);  check("up3_e1_busy", 32'(busy), 32'h0);
    to_edge(2);  check("up3_e2_busy", 32'(busy), 32'h1);
                 check("s1_e2_on", 32'(on_count1), 32'h0);
    to_edge(3);  check("s1_e3_on", 32'(on_count1), 32'h1);
    to_edge(5);  check("up3_e5_en", 32'(lamp_en), 32'h0);
                 check("s1_e5_on", 32'(on_count1), 32'h3);
                 check("s1_e5_done", 32'(done1), 32'h1);
                 check("s1_e5_busy", 32'(busy1), 32'h0);
    to_edge(6);  check("up3_e6_en", 32'(lamp_en), 32'h1);
    to_edge(9);  check("up3_e9_en", 32'(lamp_en), 32'h1);
    to_edge(10); check("up3_e10_en", 32'(lamp_en), 32'h3);
    to_edge(13); check("up3_e13_done", 32'(done), 32'h0);
                 check("up3_e13_busy", 32'(busy), 32'h1);
    to_edge(14); check("up3_e14_en", 32'(lamp_en), 32'h7);
                 check("up3_e14_done", 32'(done), 32'h1);
                 check("up3_e14_busy", 32'(busy), 32'h0);
    to_edge(15); check("up3_e15_done", 32'(done), 32'h0);
                 check("up3_done_cnt", 32'(done_cnt), 32'h1);

    // Ramp down 3 -> 1.
    al = 4'd1; edge_n = 0; done_cnt = 0;
    to_edge(5);  check("dn1_e5_en", 32'(lamp_en), 32'h7);
    to_edge(6);  check("dn1_e6_en", 32'(lamp_en), 32'h3);
    to_edge(9);  check("dn1_e9_en", 32'(lamp_en), 32'h3);
    to_edge(10); check("dn1_e10_en", 32'(lamp_en), 32'h1);
                 check("dn1_e10_done", 32'(done), 32'h1);
    to_edge(12); check("dn1_done_cnt", 32'(done_cnt), 32'h1);
                 check("dn1_busy", 32'(busy), 32'h0);

    // Redirect: heading for 8, retarget to 2 once on_count reaches 4.
    al = 4'd8; edge_n = 0; done_cnt = 0;
    to_edge(14); check("rd_e14_on", 32'(on_count), 32'h4);
    al = 4'd2;
    to_edge(15); check("rd_e15_busy", 32'(busy), 32'h1);
    to_edge(19); check("rd_e19_on", 32'(on_count), 32'h4);
    to_edge(20); check("rd_e20_on", 32'(on_count), 32'h3);
    to_edge(23); check("rd_e23_on", 32'(on_count), 32'h3);
    to_edge(24); check("rd_e24_on", 32'(on_count), 32'h2);
                 check("rd_e24_done", 32'(done), 32'h1);
    to_edge(26); check("rd_done_cnt", 32'(done_cnt), 32'h1);
                 check("rd_busy", 32'(busy), 32'h0);

    // 12-lamp instance has long since clamped at 12.
    check("n12_on", 32'(on_count12), 32'hC);
    check("n12_en", 32'(lamp_en12), 32'hFFF);
    check("n12_busy", 32'(busy12), 32'h0);

    // Reset mid-ramp at on_count 5, then re-ramp from 0 toward the held target.
    al = 4'd10; edge_n = 0;
    to_edge(14); check("rr_e14_on", 32'(on_count), 32'h5);
    rst_n = 1'b0;
    to_edge(15); check("rr_e15_en", 32'(lamp_en), 32'h0);
                 check("rr_e15_on", 32'(on_count), 32'h0);
                 check("rr_e15_busy", 32'(busy), 32'h0);
                 check("rr_e15_done", 32'(done), 32'h0);
    to_edge(16);
    rst_n = 1'b1; edge_n = 0; done_cnt = 0;
    to_edge(5);  check("rr_e5_on", 32'(on_count), 32'h0);
                 check("rr_e5_busy", 32'(busy), 32'h1);
    to_edge(6);  check("rr_e6_on", 32'(on_count), 32'h1);
    to_edge(41); check("rr_e41_on", 32'(on_count), 32'h9);
    to_edge(42); check("rr_e42_en", 32'(lamp_en), 32'h3FF);
                 check("rr_e42_done", 32'(done), 32'h1);
    to_edge(44); check("rr_done_cnt", 32'(done_cnt), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_ramp_sequencer.md
# lamp_ramp_sequencer

Consumer end of the lighting count path: takes the 4-bit active-lamp count produced by the lamp-selection logic and drives the physical lamp enables. It does not switch all lamps at once. It ramps one lamp per step interval toward the requested count, up or down, and follows target changes mid-ramp. It sits between the lamp-count logic and the lamp output pins.

## Interface
- NUM_LAMPS, default 15: number of physical lamps. Range 1..15.
- STEP_CYCLES, default 4: clock cycles per single-lamp step. Must be ≥ 1.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- active_lights  input  4  requested lamp count, unsigned 0..15. It may change on any cycle.
- lamp_en  output  NUM_LAMPS  thermometer enables; bit i is high iff i < on_count.
- on_count  output  4  number of lamps currently on.
- busy  output  1  high while ramping (state ≠ IDLE).
- done  output  1  one-cycle pulse when a ramp reaches its target.

## Operation
- Target register: tgt_q <= min(active_lights, NUM_LAMPS) every cycle. Width is 4 bits, unsigned, with no wrap.
- Step timer: 4-bit counter, 0..STEP_CYCLES-1. It is held at 0 in IDLE. On reaching terminal STEP_CYCLES-1 it resets to 0 and a step fires.
- States:
  - IDLE: on_count == tgt_q.
    - tgt_q > on_count → RAMP_UP, timer = 0.
    - tgt_q < on_count → RAMP_DOWN, timer = 0.
  - RAMP_UP, checked in priority order each cycle:
    - tgt_q == on_count → IDLE with no done pulse (target moved onto the current count).
    - tgt_q < on_count → RAMP_DOWN, timer = 0.
    - Otherwise, on a step: on_count + 1. If the new value equals tgt_q → IDLE and done.
  - RAMP_DOWN: mirror of RAMP_UP, with on_count − 1 on a step.
- on_count never leaves 0..NUM_LAMPS. Decrement at 0 and increment at NUM_LAMPS are impossible by construction; a stray attempt is a bench assertion failure.
- lamp_en is decoded from registered on_count. It must be glitch-free and may be combinational from the register only.

## Timing
- Reset (rst_n low at an edge) forces:
  - tgt_q = 0, on_count = 0, lamp_en = 0
  - state = IDLE, timer = 0, busy = 0, done = 0
- Reset mid-ramp aborts immediately; no partial step completes.
- If active_lights changes before edge k, tgt_q updates at edge k. State leaves IDLE at edge k+1.
- First on_count change is at edge k+1+STEP_CYCLES. Each further step follows every STEP_CYCLES edges.
- A full ramp of N lamps completes N·STEP_CYCLES cycles after leaving IDLE.
- done is set on the edge where on_count reaches tgt_q and clears on the next edge. busy falls on that same edge.
- If the target changes at the same edge a step fires:
  - The step applies first.
  - The new tgt_q is compared against the updated on_count on the following cycle.
- Direction reversal restarts the timer. The first reverse step therefore comes STEP_CYCLES cycles after the reversal edge.
- STEP_CYCLES = 1: one step per cycle; the timer is always at terminal.

## Structure
- Shared lighting package holds:
  - the state enum (IDLE, RAMP_UP, RAMP_DOWN)
  - the lamp-count width constant (4)
  - the maximum lamp count constant (15)
- Sub-module lamp_thermo_decode (count → NUM_LAMPS-bit thermometer). It is reused by any other block that displays lamp state.
- The top holds the target register, step timer, state register and on_count register.

## Test plan
- Reset with active_lights = 0 → lamp_en = 0, on_count = 0, busy = 0, done = 0 for 20 cycles.
- Defaults; active_lights = 3 before edge 1:
  - lamp_en = 0x0001 at edge 6, 0x0003 at edge 10, 0x0007 at edge 14.
  - done high for the cycle after edge 14; busy low from edge 14.
- From steady 3, set active_lights = 1 → lamp_en goes 0x0003 then 0x0001, 4 cycles apart; one done pulse.
- Redirect: target 8; when on_count = 4, set target 2.
  - RAMP_DOWN, timer restarts, on_count goes 3 then 2.
  - Exactly one done pulse, at reaching 2.
- NUM_LAMPS = 12, active_lights = 15 → ramp stops at on_count = 12, lamp_en = 0x0FFF, busy = 0.
- Reset asserted at on_count = 5 mid-RAMP_UP → all outputs 0 at the next edge. After release it re-ramps from 0 to the held target.
